cvs_loopback_tester: RTL and testbench

Parametrised successor to the board-level pin pass-through used in the simple FPGA CVS design. It drives CHANNELS output pins and checks the same number of looped-back input pins. Three modes are supported: registered pass-through, PRBS7 generate-and-check with per-channel lock and error counting, and walking-one. It sits between the board I/O buffers and the MMCM-derived fabric clock domain, and reports per-channel link health to software-visible status.

---
 rtl/cvs_pkg.sv | 46 ++++
 rtl/cvs_prbs7_checker.sv | 126 ++++++++++++
 rtl/cvs_loopback_tester.sv | 146 ++++++++++++++
 tb/tb_cvs_loopback_tester.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvs_pkg.sv
// ---------------------------------------------------------------------------
// cvs_pkg
//
// Shared types and constants for the CVS loopback tester.
//   mode_e       : decoded operating mode (the unused encoding 3 maps to
//                  pass-through through decode_mode()).
//   chk_state_e  : per-channel PRBS checker state.
//   PRBS7_SEED   : LFSR value loaded on reset and on every mode change.
//   PRBS7_TAP_*  : feedback taps of x^7 + x^6 + 1 (bit positions 6 and 5).
//   prbs7_step() : one shift of the Fibonacci LFSR; bit 0 receives the new
//                  bit, so bit i is the sequence delayed by i cycles.
// ---------------------------------------------------------------------------
package cvs_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_PRBS = 2'd1,
    MODE_WALK = 2'd2
  } mode_e;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  // Raw mode pins to operating mode; encoding 3 behaves as pass-through.
  function automatic mode_e decode_mode(input logic [1:0] mode_raw);
    mode_e result;
    case (mode_raw)
      2'd1:    result = MODE_PRBS;
      2'd2:    result = MODE_WALK;
      default: result = MODE_PASS;
    endcase
    return result;
  endfunction

  // s(t) = s(t-7) ^ s(t-6): shift left and insert the feedback at bit 0.
  function automatic logic [6:0] prbs7_step(input logic [6:0] state);
    return {state[5:0], state[PRBS7_TAP_A] ^ state[PRBS7_TAP_B]};
  endfunction

endpackage

// File: rtl/cvs_prbs7_checker.sv
// ---------------------------------------------------------------------------
// cvs_prbs7_checker
//
// Self-synchronising PRBS7 checker for one looped-back channel.
//
// Ports:
//   clk, rst_n    : fabric clock, asynchronous active-low reset
//   enable        : evaluate the current input bit this cycle (PRBS mode)
//   restart       : mode change; drop to SEARCH and clear the history and
//                   the run counter (the error counter is kept)
//   clear_errors  : zero the error counter; wins over a same-cycle increment
//   din           : registered loopback bit for this channel
//   locked        : high while the checker is in LOCKED
//   err_count     : saturating mismatch count, only advanced while LOCKED
//
// The checker predicts each bit from its own 7-bit history of received
// bits, so it needs no alignment with the generator.
// ---------------------------------------------------------------------------
module cvs_prbs7_checker
  import cvs_pkg::*;
#(
  parameter int ERR_W        = 16,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic             clear_errors,
  input  logic             din,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  // One counter serves both states: consecutive matches while searching,
  // consecutive mismatches while locked.
  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_COUNT - 1);

  logic [6:0]       hist_q, hist_d;
  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic pred;
  logic mismatch;

  always_comb begin
    // hist[0] is the newest bit; hist[6] is seven bits old.
    pred = hist_q[PRBS7_TAP_A] ^ hist_q[PRBS7_TAP_B];
    // An all-zero history predicts zero forever, so a zero bit arriving on
    // an empty history is flagged to expose stuck-at-0 pins.
    mismatch = (din != pred) || ((hist_q == '0) && !din);

    hist_d  = hist_q;
    state_d = state_q;
    run_d   = run_q;
    err_d   = err_q;

    if (restart) begin
      hist_d  = '0;
      state_d = SEARCH;
      run_d   = '0;
    end else if (enable) begin
      hist_d = {hist_q[5:0], din};
      case (state_q)
        SEARCH: begin
          if (mismatch) begin
            run_d = '0;
          end else if (run_q == LOCK_LAST) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end
        LOCKED: begin
          if (mismatch) begin
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
            // The mismatch that drops lock is still counted above.
            if (run_q == UNLOCK_LAST) begin
              state_d = SEARCH;
              run_d   = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else begin
            run_d = '0;
          end
        end
        default: begin
          state_d = SEARCH;
          run_d   = '0;
        end
      endcase
    end

    if (clear_errors) begin
      err_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      state_q <= SEARCH;
      run_q   <= '0;
      err_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      state_q <= state_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_count = err_q;

endmodule

// File: rtl/cvs_loopback_tester.sv
// ---------------------------------------------------------------------------
// cvs_loopback_tester
//
// Drives CHANNELS output pins and checks the same number of looped-back
// input pins. Modes: registered pass-through, PRBS7 generate-and-check and
// walking-one.
//
// Ports:
//   clk           : fabric clock (the only clock)
//   rst_n         : asynchronous active-low reset
//   mode          : 0 pass-through, 1 PRBS7, 2 walking-one, 3 as 0
//   clear_errors  : single-cycle pulse zeroing every error counter
//   in            : loopback pins, synchronous to clk
//   out           : driven pins (registered)
//   locked        : per-channel PRBS lock
//   err_count     : channel k at bits [k*ERR_W +: ERR_W]
//   err_any       : registered OR of all non-zero counters
// ---------------------------------------------------------------------------
module cvs_loopback_tester
  import cvs_pkg::*;
#(
  parameter int CHANNELS     = 5,
  parameter int ERR_W        = 16,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic                      clear_errors,
  input  logic [CHANNELS-1:0]       in,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       locked,
  output logic [CHANNELS*ERR_W-1:0] err_count,
  output logic                      err_any
);

  localparam logic [CHANNELS-1:0] WALK_FIRST = CHANNELS'(1);

  logic [CHANNELS-1:0] in_q;
  logic [1:0]          mode_q;
  logic [6:0]          lfsr_q, lfsr_d;
  logic [CHANNELS-1:0] walk_q, walk_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                err_any_q, err_any_d;

  mode_e               mode_eff;
  logic                mode_change;
  logic [6:0]          lfsr_cur;
  logic [CHANNELS-1:0] lfsr_taps;
  logic [CHANNELS-1:0] walk_rot;

  // -------------------------------------------------------------------------
  // Mode tracking and PRBS7 generator. mode_q holds the raw mode seen on the
  // previous edge; any difference (including 0 <-> 3) counts as a change.
  // On a change the LFSR value used this cycle is the seed, so the first
  // PRBS word driven after entering the mode is the seed itself.
  // -------------------------------------------------------------------------
  always_comb begin
    mode_eff    = decode_mode(mode);
    mode_change = (mode != mode_q);
    lfsr_cur    = mode_change ? PRBS7_SEED : lfsr_q;
    lfsr_d      = (mode_eff == MODE_PRBS) ? prbs7_step(lfsr_cur) : lfsr_cur;
  end

  // Every LFSR bit is a delayed copy of the same sequence, so channels wrap
  // onto the seven taps and each still carries valid PRBS7.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_taps
      assign lfsr_taps[gi] = lfsr_cur[gi % 7];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Walking-one: restarts at bit 0 on a mode change and rotates left while
  // the walking mode is selected. The OR of both shifts handles the wrap and
  // degenerates correctly for a single channel.
  // -------------------------------------------------------------------------
  assign walk_rot = (walk_q << 1) | (walk_q >> (CHANNELS - 1));

  always_comb begin
    walk_d = walk_q;
    if (mode_change) begin
      walk_d = WALK_FIRST;
    end else if (mode_eff == MODE_WALK) begin
      walk_d = walk_rot;
    end
  end

  // -------------------------------------------------------------------------
  // Output mux and health summary.
  // -------------------------------------------------------------------------
  always_comb begin
    case (mode_eff)
      MODE_PRBS: out_d = lfsr_taps;
      MODE_WALK: out_d = walk_d;
      default:   out_d = in_q;
    endcase
    // Sampled from the registered counters, so err_any trails them by one edge.
    err_any_d = |err_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= '0;
      mode_q    <= 2'd0;
      lfsr_q    <= PRBS7_SEED;
      walk_q    <= '0;
      out_q     <= '0;
      err_any_q <= 1'b0;
    end else begin
      in_q      <= in;
      mode_q    <= mode;
      lfsr_q    <= lfsr_d;
      walk_q    <= walk_d;
      out_q     <= out_d;
      err_any_q <= err_any_d;
    end
  end

  assign out     = out_q;
  assign err_any = err_any_q;

  // -------------------------------------------------------------------------
  // Per-channel checkers, fed from the registered input stage.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chk
      cvs_prbs7_checker #(
        .ERR_W        (ERR_W),
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
      ) u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (mode_eff == MODE_PRBS),
        .restart      (mode_change),
        .clear_errors (clear_errors),
        .din          (in_q[gi]),
        .locked       (locked[gi]),
        .err_count    (err_count[gi*ERR_W +: ERR_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_cvs_loopback_tester.sv
// ---------------------------------------------------------------------------
// Bench for cvs_loopback_tester. Two instances share all inputs: the default
// build and an ERR_W=4 build for counter saturation. A behavioural model
// predicts every edge; its prediction is queued when the stimulus is applied
// and a separate monitor compares it one step after each rising edge.
// ---------------------------------------------------------------------------
module tb_cvs_loopback_tester;

  localparam int CH  = 5;
  localparam int EW  = 16;
  localparam int EW4 = 4;
  localparam int LC  = 16;
  localparam int UC  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [1:0]      mode = 2'd0;
  logic            clear_errors = 1'b0;
  logic [CH-1:0]   in_v = '0;

  logic [CH-1:0]     out, locked, out4, locked4;
  logic [CH*EW-1:0]  err_count;
  logic [CH*EW4-1:0] err_count4;
  logic              err_any, err_any4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cvs_loopback_tester #(.CHANNELS(CH), .ERR_W(EW), .LOCK_COUNT(LC), .UNLOCK_COUNT(UC)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clear_errors(clear_errors), .in(in_v),
    .out(out), .locked(locked), .err_count(err_count), .err_any(err_any));

  cvs_loopback_tester #(.CHANNELS(CH), .ERR_W(EW4), .LOCK_COUNT(LC), .UNLOCK_COUNT(UC)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clear_errors(clear_errors), .in(in_v),
    .out(out4), .locked(locked4), .err_count(err_count4), .err_any(err_any4));

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [CH-1:0]     out;
    logic [CH-1:0]     locked;
    logic [CH*EW-1:0]  err;
    logic [CH*EW4-1:0] err4;
    logic              any;
    logic              any4;
  } exp_t;

  exp_t exp_q[$];

  bit            seq[127];        // one PRBS7 period, starting from the seed
  logic [1:0]    m_mode_prev;
  logic [CH-1:0] m_in_q, m_out;
  int            m_pj, m_w;
  bit            m_past[CH][7];   // m_past[k][i]: bit received i+1 evaluations ago
  bit            m_locked[CH];
  int            m_run[CH];
  int            m_err[CH];
  int            m_err4[CH];
  bit            m_any, m_any4;

  logic [CH-1:0] out_hist[$];     // model outputs, newest first (loopback line)
  bit            loop_en = 0;
  logic [CH-1:0] direct_in = '0;
  logic [CH-1:0] flip_mask = '0, stuck1_mask = '0, stuck0_mask = '0;

  task automatic model_reset();
    m_mode_prev = 2'd0; m_in_q = '0; m_out = '0; m_pj = 0; m_w = 0;
    m_any = 0; m_any4 = 0;
    for (int k = 0; k < CH; k++) begin
      for (int i = 0; i < 7; i++) m_past[k][i] = 0;
      m_locked[k] = 0; m_run[k] = 0; m_err[k] = 0; m_err4[k] = 0;
    end
    out_hist.delete();
    repeat (3) out_hist.push_back('0);
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic [1:0] md, input bit clr, input logic [CH-1:0] din);
    bit change, any_old, any4_old, b, pred, allz, mis;
    int eff;
    exp_t e;
    change = (md != m_mode_prev);
    eff = (md == 2'd1) ? 1 : (md == 2'd2) ? 2 : 0;
    any_old = 0; any4_old = 0;
    for (int k = 0; k < CH; k++) begin
      if (m_err[k] != 0) any_old = 1;
      if (m_err4[k] != 0) any4_old = 1;
    end
    if (change) begin m_pj = 0; m_w = 0; end
    if (eff == 0) m_out = m_in_q;
    else if (eff == 1) begin
      for (int k = 0; k < CH; k++) m_out[k] = seq[(m_pj + 6 - (k % 7)) % 127];
      m_pj = m_pj + 1;
    end else begin
      m_out = '0; m_out[m_w] = 1'b1; m_w = (m_w + 1) % CH;
    end
    for (int k = 0; k < CH; k++) begin
      if (change) begin
        for (int i = 0; i < 7; i++) m_past[k][i] = 0;
        m_locked[k] = 0; m_run[k] = 0;
      end else if (eff == 1) begin
        b = m_in_q[k];
        pred = m_past[k][6] ^ m_past[k][5];
        allz = 1;
        for (int i = 0; i < 7; i++) if (m_past[k][i]) allz = 0;
        mis = (b != pred) || (allz && !b);
        if (!m_locked[k]) begin
          if (mis) m_run[k] = 0;
          else begin
            m_run[k]++;
            if (m_run[k] == LC) begin m_locked[k] = 1; m_run[k] = 0; end
          end
        end else begin
          if (mis) begin
            if (m_err[k] < (1 << EW) - 1) m_err[k]++;
            if (m_err4[k] < (1 << EW4) - 1) m_err4[k]++;
            m_run[k]++;
            if (m_run[k] == UC) begin m_locked[k] = 0; m_run[k] = 0; end
          end else m_run[k] = 0;
        end
        for (int i = 6; i > 0; i--) m_past[k][i] = m_past[k][i-1];
        m_past[k][0] = b;
      end
      if (clr) begin m_err[k] = 0; m_err4[k] = 0; end
    end
    m_any = any_old; m_any4 = any4_old;
    m_in_q = din; m_mode_prev = md;
    e.out = m_out; e.any = m_any; e.any4 = m_any4;
    for (int k = 0; k < CH; k++) begin
      e.locked[k] = m_locked[k];
      e.err[k*EW +: EW] = EW'(m_err[k]);
      e.err4[k*EW4 +: EW4] = EW4'(m_err4[k]);
    end
    exp_q.push_back(e);
  endtask

  // Called at a falling edge: apply inputs, queue the prediction, advance one cycle.
  task automatic step(input logic [1:0] md, input bit clr);
    logic [CH-1:0] v;
    v = loop_en ? out_hist[2] : direct_in;
    v = ((v ^ flip_mask) | stuck1_mask) & ~stuck0_mask;
    flip_mask = '0;
    in_v = v; mode = md; clear_errors = clr;
    model_step(md, clr, v);
    out_hist.push_front(m_out);
    out_hist.delete(3);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic chk_min(input string name, input int act, input int min_v);
    checks++;
    if (act < min_v) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min_v);
    end
  endtask

  // -------------------------------------------------------------- monitor
  int cyc = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("out@%0d", cyc), out, e.out);
        chk($sformatf("out4@%0d", cyc), out4, e.out);
        chk($sformatf("locked@%0d", cyc), locked, e.locked);
        chk($sformatf("locked4@%0d", cyc), locked4, e.locked);
        chk($sformatf("err_count@%0d", cyc), err_count, e.err);
        chk($sformatf("err_count4@%0d", cyc), err_count4, e.err4);
        chk($sformatf("err_any@%0d", cyc), err_any, e.any);
        chk($sformatf("err_any4@%0d", cyc), err_any4, e.any4);
      end
    end
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ------------------------------------------------------------- stimulus
  logic [CH*EW-1:0] tmp_err;
  logic [CH-1:0]    all_ones;

  initial begin
    all_ones = '1;
    for (int n = 0; n < 7; n++) seq[n] = 1;
    for (int n = 7; n < 127; n++) seq[n] = seq[n-7] ^ seq[n-6];
    model_reset();

    // Reset state, observed with reset held and no clock edge required.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out", out, 0);
    chk("reset_locked", locked, 0);
    chk("reset_err_count", err_count, 0);
    chk("reset_err_any", err_any, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[%0t] reset released", $time);

    // Pass-through, two-edge latency, then random data with modes 0 and 3.
    loop_en = 0;
    direct_in = 5'b10110;
    step(2'd0, 0);
    direct_in = CH'($urandom);
    step(2'd0, 0);
    chk("pass_latency", out, 5'b10110);
    for (int i = 0; i < 20; i++) begin
      direct_in = CH'($urandom);
      step($urandom_range(0, 1) ? 2'd0 : 2'd3, 0);
    end
    $display("[%0t] pass-through phase done", $time);

    // Walking one with wrap.
    step(2'd2, 0);
    chk("walk_first", out, 1);
    repeat (4) step(2'd2, 0);
    chk("walk_msb", out, 5'b10000);
    step(2'd2, 0);
    chk("walk_wrap", out, 1);
    repeat (6) step(2'd2, 0);
    $display("[%0t] walking-one phase done", $time);

    // PRBS loopback through a 3-cycle external delay.
    loop_en = 1;
    repeat (30) step(2'd1, 0);
    chk("prbs_lock30", locked, all_ones);
    repeat (10000) step(2'd1, 0);
    chk("prbs_long_err", err_count, 0);
    chk("prbs_long_err4", err_count4, 0);
    $display("[%0t] PRBS 10000-cycle run done", $time);

    // Single flipped bit on channel 2: three mismatches, lock held.
    flip_mask = 5'b00100;
    repeat (20) step(2'd1, 0);
    chk("flip_err2", err_count[2*EW +: EW], 3);
    chk("flip_err2_w4", err_count4[2*EW4 +: EW4], 3);
    tmp_err = err_count; tmp_err[2*EW +: EW] = '0;
    chk("flip_others", tmp_err, 0);
    chk("flip_locked2", locked[2], 1);
    $display("[%0t] single-flip phase done", $time);

    // Clear landing on the same edge as the third mismatch.
    step(2'd1, 1);
    flip_mask = 5'b00100;
    step(2'd1, 0);
    repeat (7) step(2'd1, 0);
    step(2'd1, 1);
    chk("clear_wins", err_count[2*EW +: EW], 0);
    repeat (10) step(2'd1, 0);
    chk("clear_after", err_count[2*EW +: EW], 0);
    $display("[%0t] clear-collision phase done", $time);

    // Six flips: 18 on the wide counter, saturated at 15 on the narrow one.
    for (int f = 0; f < 6; f++) begin
      flip_mask = 5'b00100;
      repeat (11 + $urandom_range(0, 3)) step(2'd1, 0);
    end
    chk("sat_err4", err_count4[2*EW4 +: EW4], 15);
    chk("sat_err16", err_count[2*EW +: EW], 18);
    $display("[%0t] saturation phase done", $time);

    // Stuck-at-1 then stuck-at-0 on channel 0.
    for (int s = 0; s < 2; s++) begin
      step(2'd1, 1);
      if (s == 0) stuck1_mask = 5'b00001; else stuck0_mask = 5'b00001;
      repeat (40 + $urandom_range(0, 10)) step(2'd1, 0);
      chk($sformatf("stuck%0d_unlocked", 1 - s), locked[0], 0);
      chk_min($sformatf("stuck%0d_err0", 1 - s), int'(err_count[EW-1:0]), UC);
      chk($sformatf("stuck%0d_others_locked", 1 - s), locked[CH-1:1], all_ones[CH-1:1]);
      stuck1_mask = '0; stuck0_mask = '0;
      repeat (30) step(2'd1, 0);
      chk($sformatf("stuck%0d_relock", 1 - s), locked, all_ones);
      $display("[%0t] stuck-at-%0d phase done", $time, 1 - s);
    end

    // Mode change keeps counters but drops lock.
    step(2'd1, 1);
    flip_mask = 5'b00010;
    repeat (12) step(2'd1, 0);
    step(2'd2, 0);
    chk("modechg_unlock", locked, 0);
    chk("modechg_keep_err", err_count[EW +: EW], 3);
    repeat (4) step(2'd2, 0);
    repeat (30) step(2'd1, 0);
    chk("modechg_relock", locked, all_ones);
    chk("modechg_err_after", err_count[EW +: EW], 3);
    $display("[%0t] mode-change phase done", $time);

    // Asynchronous reset in the middle of a PRBS run.
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out", out, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_err4", err_count4, 0);
    chk("midrst_err_any", err_any, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    loop_en = 0;
    for (int i = 0; i < 6; i++) begin
      direct_in = CH'($urandom);
      step(2'd0, 0);
    end
    $display("[%0t] mid-run reset phase done", $time);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
